// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, loader state type and loader error codes.
// INSTR_LOADER_CHECKSUM_EN adds the checksum-verify state to the loader state type.
package cpu_pkg;

  localparam logic [3:0] OP_HALT  = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_BGT   = 4'b0100;
  localparam logic [3:0] OP_BLT   = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_JMP   = 4'b0111;
  localparam logic [3:0] OP_LBU   = 4'b1010;
  localparam logic [3:0] OP_SB    = 4'b1011;
  localparam logic [3:0] OP_LW    = 4'b1100;
  localparam logic [3:0] OP_SW    = 4'b1101;
  localparam logic [3:0] OP_TYPEA = 4'b1111;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;
  localparam logic [1:0] ERR_CHECKSUM = 2'b11;

`ifdef INSTR_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StHi, StLo, StWrite, StDone, StErr, StChk} loader_state_e;
`else
  typedef enum logic [2:0] {StIdle, StHi, StLo, StWrite, StDone, StErr} loader_state_e;
`endif

endpackage

// File: rtl/opcode_legal.sv
// Combinational opcode decoder: flags the opcodes the control unit can execute.
module opcode_legal
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       legal
);

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_HALT, OP_ANDI, OP_ORI, OP_BGT, OP_BLT, OP_BEQ, OP_JMP,
      OP_LBU, OP_SB, OP_LW, OP_SW, OP_TYPEA: legal = 1'b1;
      default:                                legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_loader.sv
// Program loader: assembles big-endian 16-bit words from a byte stream and writes them to imem.
// INSTR_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte verified after the halt word.
module instr_loader
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_count
);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [1:0]        code_q, code_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              op_legal;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]        xor_q, xor_d;
`endif

  // Opcode comes from the high byte captured in HI, so it is valid during LO.
  opcode_legal u_opcode_legal (
    .opcode (word_q[DATA_W-1 -: 4]),
    .legal  (op_legal)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    count_d = count_q;
    code_d  = code_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    xor_d   = xor_q;
`endif
    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StHi;
          addr_d  = '0;
          count_d = '0;
          code_d  = ERR_NONE;
`ifdef INSTR_LOADER_CHECKSUM_EN
          xor_d   = '0;
`endif
        end
      end
      StHi: begin
        if (byte_valid) begin
          word_d[DATA_W-1 -: 8] = byte_in;
          state_d               = StLo;
`ifdef INSTR_LOADER_CHECKSUM_EN
          xor_d                 = xor_q ^ byte_in;
`endif
        end
      end
      StLo: begin
        if (byte_valid) begin
          word_d[7:0] = byte_in;
`ifdef INSTR_LOADER_CHECKSUM_EN
          xor_d       = xor_q ^ byte_in;
`endif
          if (op_legal) begin
            state_d = StWrite;
          end else begin
            state_d = StErr;
            code_d  = ERR_ILLEGAL;
          end
        end
      end
      StWrite: begin
        count_d = count_q + (ADDR_W+1)'(1);
        if (word_q[DATA_W-1 -: 4] == OP_HALT) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          state_d = StChk;
`else
          state_d = StDone;
`endif
        end else if (addr_q == {ADDR_W{1'b1}}) begin
          state_d = StErr;
          code_d  = ERR_OVERFLOW;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = StHi;
        end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      StChk: begin
        if (byte_valid) begin
          if (byte_in == xor_q) begin
            state_d = StDone;
          end else begin
            state_d = StErr;
            code_d  = ERR_CHECKSUM;
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    busy_d  = (state_d == StHi) || (state_d == StLo) || (state_d == StWrite);
    ready_d = (state_d == StHi) || (state_d == StLo);
`ifdef INSTR_LOADER_CHECKSUM_EN
    busy_d  = busy_d || (state_d == StChk);
    ready_d = ready_d || (state_d == StChk);
`endif
    we_d    = (state_d == StWrite);
    done_d  = (state_d == StDone);
    error_d = (state_d == StErr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      word_q  <= '0;
      count_q <= '0;
      code_q  <= ERR_NONE;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      count_q <= count_d;
      code_q  <= code_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  // A reset arriving during WRITE must suppress that cycle's memory write.
  assign imem_we    = we_q & ~rst;
  assign imem_addr  = addr_q;
  assign imem_wdata = word_q;
  assign byte_ready = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign err_code   = code_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: stream-level reference model plus directed literal checks.
module tb_instr_loader;

  localparam int unsigned AW = 8;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    byte_in = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_wdata;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    err_code;
  logic [AW:0]   word_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  bq[$];
  wr_t         exp_q[$];
  logic [15:0] mem [0:(1<<AW)-1];
  int          we_count;
  int          exp_writes;
  int          n_send;
  logic        exp_done, exp_err;
  logic [1:0]  exp_code;
  int          exp_wc;
  logic [15:0] legal_mask = 16'hBCF7;

  instr_loader #(.ADDR_W(AW), .DATA_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Every write strobe must match the next write the model predicts.
  always @(negedge clk) begin
    if (imem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_imem_we", 32'(imem_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("imem_addr", 32'(imem_addr), 32'(w.a));
        check("imem_wdata", 32'(imem_wdata), 32'(w.d));
      end
      mem[imem_addr] = imem_wdata;
      we_count++;
    end
  end

  // Walks the byte stream by the loader's rules and predicts writes and final status.
  function automatic void model_load();
    int            i = 0;
    logic [AW-1:0] addr = '0;
    logic [7:0]    x = '0;
    logic [15:0]   w;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_code = 2'b00;
    exp_wc   = 0;
    while (i + 1 < bq.size()) begin
      w = {bq[i], bq[i+1]};
      x = x ^ bq[i] ^ bq[i+1];
      i += 2;
      if (!legal_mask[w[15:12]]) begin
        exp_err  = 1'b1;
        exp_code = 2'b01;
        break;
      end
      exp_q.push_back('{a: addr, d: w});
      exp_wc++;
      if (w[15:12] == 4'h0) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
        if (i >= bq.size()) bq.push_back(x);
        if (bq[i] == x) exp_done = 1'b1;
        else begin
          exp_err  = 1'b1;
          exp_code = 2'b11;
        end
        i++;
`else
        exp_done = 1'b1;
`endif
        break;
      end
      if (addr == {AW{1'b1}}) begin
        exp_err  = 1'b1;
        exp_code = 2'b10;
        break;
      end
      addr++;
    end
    n_send = i;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_in    = b;
    while (!byte_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check("byte_handshake_timeout", 32'd1, 32'd0);
      byte_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 byte_valid = 1'b0;
    end
  endtask

  task automatic start_load();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_load(input int gapmax);
    int n = 0;
    model_load();
    exp_writes = exp_q.size();
    we_count   = 0;
    start_load();
    for (int j = 0; j < n_send; j++) send_byte(bq[j], $urandom_range(0, gapmax));
    while (!(done || error) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("load_end_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk);
    check("done", 32'(done), 32'(exp_done));
    check("error", 32'(error), 32'(exp_err));
    check("err_code", 32'(err_code), 32'(exp_code));
    check("word_count", 32'(word_count), 32'(exp_wc));
    check("busy_after_load", 32'(busy), 32'd0);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    check("we_count", 32'(we_count), 32'(exp_writes));
    exp_q.delete();
  endtask

  function automatic logic [15:0] rand_word();
    logic [3:0] op;
    logic [3:0] legal_ops [11];
    legal_ops = '{4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA, 4'hB, 4'hC, 4'hD, 4'hF};
    if ($urandom_range(0, 11) == 0) op = 4'($urandom_range(0, 15));
    else op = legal_ops[$urandom_range(0, 10)];
    return {op, 12'($urandom)};
  endfunction

  initial begin
    logic [15:0] w;
    we_count = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);

    // Directed: three words ending in halt.
    bq = '{8'hF0, 8'h12, 8'h10, 8'h34, 8'h00, 8'h00};
    run_load(0);
    check("lit_mem0", 32'(mem[0]), 32'hF012);
    check("lit_mem1", 32'(mem[1]), 32'h1034);
    check("lit_mem2", 32'(mem[2]), 32'h0000);
    check("lit_wc3", 32'(word_count), 32'd3);
    check("lit_done", 32'(done), 32'd1);

    // Directed: illegal opcode on the second word.
    bq = '{8'h10, 8'h00, 8'h30, 8'hFF};
    run_load(0);
    check("lit_ill_mem0", 32'(mem[0]), 32'h1000);
    check("lit_ill_code", 32'(err_code), 32'd1);
    check("lit_ill_wc", 32'(word_count), 32'd1);
    check("lit_ill_we", 32'(we_count), 32'd1);

    // Overflow: fill every address with non-halt words.
    bq.delete();
    for (int k = 0; k < (1 << AW); k++) begin
      w = {4'h1, 12'($urandom)};
      bq.push_back(w[15:8]);
      bq.push_back(w[7:0]);
    end
    run_load(0);
    check("lit_ovf_code", 32'(err_code), 32'd2);
    check("lit_ovf_wc", 32'(word_count), 32'd256);
    check("lit_ovf_err", 32'(error), 32'd1);

    // Random streams with random byte gaps.
    for (int t = 0; t < 12; t++) begin
      int len;
      bq.delete();
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        w = (k == len - 1) ? {4'h0, 12'($urandom)} : rand_word();
        bq.push_back(w[15:8]);
        bq.push_back(w[7:0]);
      end
      run_load(5);
    end

    // Reset right after the first high byte abandons the load.
    start_load();
    send_byte(8'h1A, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(byte_ready), 32'd0);
    check("mid_rst_wc", 32'(word_count), 32'd0);
    check("mid_rst_flags", 32'({done, error, err_code}), 32'd0);
    check("mid_rst_wdata", 32'(imem_wdata), 32'd0);
    bq = '{8'h2C, 8'h33, 8'h01, 8'h02};
    bq.push_back(8'h00);
    bq.push_back(8'h07);
    run_load(2);
    check("lit_after_rst_mem0", 32'(mem[0]), 32'h2C33);

`ifdef INSTR_LOADER_CHECKSUM_EN
    bq = '{8'h12, 8'h34, 8'h00, 8'h00, 8'h26};
    run_load(0);
    check("lit_chk_ok", 32'(done), 32'd1);
    bq = '{8'h12, 8'h34, 8'h00, 8'h00, 8'h27};
    run_load(0);
    check("lit_chk_bad_err", 32'(error), 32'd1);
    check("lit_chk_bad_code", 32'(err_code), 32'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
